countdown_display_scan: RTL and testbench

- Downstream consumer of the countdown stage.
- Takes the three BCD time digits plus an armed flag and drives a 4-digit, time-multiplexed, active-low seven-segment display.
- Adds low-time blinking, an expiry latch and an armed-status glyph on the leftmost digit.
- Sits between the countdown logic and the board display pins.

---
 rtl/countdown_display_scan.sv | 185 ++++++++++++++++++
 tb/tb_countdown_display_scan.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_display_scan.sv
// rtl/countdown_display_scan.sv - 4-digit multiplexed active-low seven-segment driver for the countdown stage
// Define COUNTDOWN_LZB_EN to blank leading zeros on the hundreds/tens digits.

module countdown_display_scan #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLINK_DIV    = 12500000,
    parameter int BLINK_THRESH = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] value_three,
    input  logic [3:0] value_two,
    input  logic [3:0] value_one,
    input  logic       armed,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp,
    output logic       expired
);

    localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);
    localparam logic [9:0] THRESH = 10'(BLINK_THRESH);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_ALL   = 7'b0000000;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    typedef enum logic {
        BLINK_ON  = 1'b0,
        BLINK_OFF = 1'b1
    } blink_state_t;

    blink_state_t     blink_state;
    blink_state_t     blink_state_next;
    logic [PRE_W-1:0] prescaler;
    logic [PRE_W-1:0] prescaler_next;
    logic [1:0]       idx;
    logic [1:0]       idx_next;
    logic [BLK_W-1:0] blink_cnt;
    logic [BLK_W-1:0] blink_cnt_next;
    logic             armed_d;
    logic             expired_next;
    logic [6:0]       seg_next;
    logic [3:0]       an_next;
    logic             dp_next;

    logic             digits_valid;
    logic             all_zero;
    logic             armed_rise;
    logic             blink_active;
    logic             scan_wrap;
    logic [9:0]       total;
    logic             blank_three;
    logic             blank_two;

    function automatic logic [6:0] decode_bcd(input logic [3:0] digit);
        case (digit)
            4'd0:    decode_bcd = 7'b1000000;
            4'd1:    decode_bcd = 7'b1111001;
            4'd2:    decode_bcd = 7'b0100100;
            4'd3:    decode_bcd = 7'b0110000;
            4'd4:    decode_bcd = 7'b0011001;
            4'd5:    decode_bcd = 7'b0010010;
            4'd6:    decode_bcd = 7'b0000010;
            4'd7:    decode_bcd = 7'b1111000;
            4'd8:    decode_bcd = 7'b0000000;
            4'd9:    decode_bcd = 7'b0010000;
            default: decode_bcd = SEG_DASH;
        endcase
    endfunction

    assign digits_valid = (value_three <= 4'd9) && (value_two <= 4'd9) && (value_one <= 4'd9);
    assign all_zero     = (value_three == 4'd0) && (value_two == 4'd0) && (value_one == 4'd0);
    assign armed_rise   = armed && !armed_d;
    assign scan_wrap    = (prescaler == PRE_LAST);

    // A malformed digit must never trigger the low-time blink, so treat it as the maximum time.
    assign total = digits_valid
                 ? (10'(value_three) * 10'd100 + 10'(value_two) * 10'd10 + 10'(value_one))
                 : 10'd999;

    assign blink_active = (armed && (total <= THRESH)) || expired;

`ifdef COUNTDOWN_LZB_EN
    assign blank_three = (value_three == 4'd0);
    assign blank_two   = (value_three == 4'd0) && (value_two == 4'd0);
`else
    assign blank_three = 1'b0;
    assign blank_two   = 1'b0;
`endif

    always_comb begin
        prescaler_next   = prescaler + PRE_W'(1);
        idx_next         = idx;
        blink_cnt_next   = blink_cnt;
        blink_state_next = blink_state;
        expired_next     = expired;
        seg_next         = SEG_BLANK;
        an_next          = AN_OFF;
        dp_next          = 1'b1;

        if (scan_wrap) begin
            prescaler_next = '0;
            idx_next       = idx + 2'd1;
        end

        if (!blink_active) begin
            blink_cnt_next   = '0;
            blink_state_next = BLINK_ON;
        end else if (blink_cnt == BLK_LAST) begin
            blink_cnt_next   = '0;
            blink_state_next = (blink_state == BLINK_ON) ? BLINK_OFF : BLINK_ON;
        end else begin
            blink_cnt_next = blink_cnt + BLK_W'(1);
        end

        // Set takes priority so a re-arm straight onto 000 still reports expiry.
        if (armed_rise) begin
            expired_next = 1'b0;
        end
        if (armed && all_zero) begin
            expired_next = 1'b1;
        end

        case (idx)
            2'd0: begin
                an_next  = 4'b1110;
                seg_next = decode_bcd(value_one);
            end
            2'd1: begin
                an_next  = 4'b1101;
                seg_next = blank_two ? SEG_BLANK : decode_bcd(value_two);
                dp_next  = !(armed && !blank_two);
            end
            2'd2: begin
                an_next  = 4'b1011;
                seg_next = blank_three ? SEG_BLANK : decode_bcd(value_three);
            end
            default: begin
                an_next = 4'b0111;
                if (expired) begin
                    seg_next = SEG_ALL;
                end else if (armed) begin
                    seg_next = SEG_DASH;
                end else begin
                    seg_next = SEG_BLANK;
                end
            end
        endcase

        if (blink_state == BLINK_OFF) begin
            an_next  = AN_OFF;
            seg_next = SEG_BLANK;
            dp_next  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler   <= '0;
            idx         <= 2'd0;
            blink_cnt   <= '0;
            blink_state <= BLINK_ON;
            armed_d     <= 1'b0;
            expired     <= 1'b0;
            seg         <= SEG_BLANK;
            an          <= AN_OFF;
            dp          <= 1'b1;
        end else begin
            prescaler   <= prescaler_next;
            idx         <= idx_next;
            blink_cnt   <= blink_cnt_next;
            blink_state <= blink_state_next;
            armed_d     <= armed;
            expired     <= expired_next;
            seg         <= seg_next;
            an          <= an_next;
            dp          <= dp_next;
        end
    end

endmodule

// File: tb/tb_countdown_display_scan.sv
// tb/tb_countdown_display_scan.sv - scoreboard bench for countdown_display_scan
// Expected outputs are queued per cycle from a reference model and checked one clock later.

module tb_countdown_display_scan;

    localparam int RD = 4;
    localparam int BD = 8;
    localparam int TH = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] value_three;
    logic [3:0] value_two;
    logic [3:0] value_one;
    logic       armed;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;
    logic       expired;

    int checks = 0;
    int errors = 0;
    int blanks;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       expired_v;
    } exp_t;

    exp_t sb_q[$];

    int m_pre;
    int m_idx;
    int m_bcnt;
    bit m_bon;
    bit m_armed_d;
    bit m_exp;

    countdown_display_scan #(
        .REFRESH_DIV (RD),
        .BLINK_DIV   (BD),
        .BLINK_THRESH(TH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .value_three(value_three),
        .value_two  (value_two),
        .value_one  (value_one),
        .armed      (armed),
        .seg        (seg),
        .an         (an),
        .dp         (dp),
        .expired    (expired)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, got, want);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    task automatic model_push();
        exp_t e;
        int   t;
        bit   ok;
        bit   all0;
        bit   act;
        bit   lz3;
        bit   lz2;
        ok   = (value_three < 10) && (value_two < 10) && (value_one < 10);
        t    = ok ? (int'(value_three) * 100 + int'(value_two) * 10 + int'(value_one)) : 999;
        all0 = (value_three == 0) && (value_two == 0) && (value_one == 0);
`ifdef COUNTDOWN_LZB_EN
        lz3 = (value_three == 0);
        lz2 = (value_three == 0) && (value_two == 0);
`else
        lz3 = 1'b0;
        lz2 = 1'b0;
`endif
        e.an  = 4'hF;
        e.seg = 7'h7F;
        e.dp  = 1'b1;
        if (m_bon) begin
            case (m_idx)
                0: begin
                    e.an  = 4'b1110;
                    e.seg = seg_of(value_one);
                end
                1: begin
                    e.an  = 4'b1101;
                    e.seg = lz2 ? 7'h7F : seg_of(value_two);
                    e.dp  = (armed && !lz2) ? 1'b0 : 1'b1;
                end
                2: begin
                    e.an  = 4'b1011;
                    e.seg = lz3 ? 7'h7F : seg_of(value_three);
                end
                default: begin
                    e.an  = 4'b0111;
                    e.seg = m_exp ? 7'b0000000 : (armed ? 7'b0111111 : 7'h7F);
                end
            endcase
        end
        act = (armed && (t <= TH)) || m_exp;
        if (!act) begin
            m_bcnt = 0;
            m_bon  = 1'b1;
        end else if (m_bcnt == BD - 1) begin
            m_bcnt = 0;
            m_bon  = !m_bon;
        end else begin
            m_bcnt++;
        end
        if (armed && !m_armed_d) m_exp = 1'b0;
        if (armed && all0) m_exp = 1'b1;
        m_armed_d = armed;
        if (m_pre == RD - 1) begin
            m_pre = 0;
            m_idx = (m_idx + 1) % 4;
        end else begin
            m_pre++;
        end
        e.expired_v = m_exp;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        model_push();
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_eq("sb_an", an, e.an);
        check_eq("sb_seg", seg, e.seg);
        check_eq("sb_dp", dp, e.dp);
        check_eq("sb_expired", expired, e.expired_v);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1;
        check_eq({tag, "_an"}, an, 4'hF);
        check_eq({tag, "_seg"}, seg, 7'h7F);
        check_eq({tag, "_dp"}, dp, 1'b1);
        check_eq({tag, "_expired"}, expired, 1'b0);
        m_pre = 0; m_idx = 0; m_bcnt = 0; m_bon = 1'b1; m_armed_d = 1'b0; m_exp = 1'b0;
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1;
        check_eq({tag, "_hold_an"}, an, 4'hF);
        reset = 1'b0;
    endtask

    task automatic find_digit(input string tag, input logic [3:0] a, input logic [6:0] s, input logic d);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 24 && !found; i++) begin
            tick();
            if (an == a) found = 1'b1;
        end
        check_eq({tag, "_found"}, found, 1'b1);
        if (found) begin
            check_eq({tag, "_seg"}, seg, s);
            check_eq({tag, "_dp"}, dp, d);
        end
    endtask

    task automatic wait_first(input string tag, input logic [3:0] a);
        logic [3:0] prev;
        bit         hit;
        hit  = 1'b0;
        prev = an;
        for (int i = 0; i < 40 && !hit; i++) begin
            tick();
            if (an == a && prev != a) hit = 1'b1;
            prev = an;
        end
        check_eq({tag, "_seen"}, hit, 1'b1);
    endtask

    task automatic run_count(input int n, output int nb);
        nb = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (an == 4'hF) nb++;
        end
    endtask

    initial begin
        value_three = 4'd3;
        value_two   = 4'd4;
        value_one   = 4'd5;
        armed       = 1'b0;
        #2;
        do_reset("rst_init");

        armed = 1'b1;
        find_digit("idx2_3", 4'b1011, 7'b0110000, 1'b1);
        find_digit("idx1_4", 4'b1101, 7'b0011001, 1'b0);
        find_digit("idx0_5", 4'b1110, 7'b0010010, 1'b1);
        find_digit("idx3_dash", 4'b0111, 7'b0111111, 1'b1);

        wait_first("pre_rst_idx2", 4'b1011);
        do_reset("rst_mid");
        for (int i = 0; i < RD; i++) begin
            tick();
            check_eq("post_rst_idx0", an, 4'b1110);
        end
        tick();
        check_eq("post_rst_idx1", an, 4'b1101);

        value_three = 4'd0; value_two = 4'hC; value_one = 4'd0;
        find_digit("idx1_bad", 4'b1101, 7'b0111111, 1'b0);
        run_count(32, blanks);
        check_eq("bad_no_blink", blanks, 0);
        check_eq("bad_no_expire", expired, 1'b0);

        value_two = 4'd1; value_one = 4'd1;
        run_count(32, blanks);
        check_eq("t011_no_blink", blanks, 0);
        value_one = 4'd0;
        run_count(BD, blanks);
        check_eq("t010_on1", blanks, 0);
        run_count(BD, blanks);
        check_eq("t010_off1", blanks, BD);
        run_count(BD, blanks);
        check_eq("t010_on2", blanks, 0);
        run_count(BD, blanks);
        check_eq("t010_off2", blanks, BD);
        armed = 1'b0;
        tick();
        tick();
        run_count(24, blanks);
        check_eq("disarm_no_blink", blanks, 0);

        value_three = 4'd1; value_two = 4'd2; value_one = 4'd0; armed = 1'b1;
        run_count(8, blanks);
        check_eq("t120_no_blink", blanks, 0);
        wait_first("pre_exp_idx2", 4'b1011);
        value_three = 4'd0; value_two = 4'd0; value_one = 4'd0;
        tick();
        check_eq("exp_set", expired, 1'b1);
        find_digit("idx3_allon", 4'b0111, 7'b0000000, 1'b1);
        run_count(24, blanks);
        check_eq("exp_blinks", blanks > 0, 1);
        armed = 1'b0;
        run_count(16, blanks);
        check_eq("exp_hold", expired, 1'b1);
        check_eq("exp_blink_disarmed", blanks > 0, 1);
        value_three = 4'd1; value_two = 4'd2; value_one = 4'd0; armed = 1'b1;
        tick();
        check_eq("exp_clear", expired, 1'b0);
        armed = 1'b0;
        tick();
        value_three = 4'd0; value_two = 4'd0; value_one = 4'd0;
        tick();
        check_eq("no_set_disarmed", expired, 1'b0);
        armed = 1'b1;
        tick();
        check_eq("rise_zero_set", expired, 1'b1);

        armed = 1'b0;
        value_three = 4'd0; value_two = 4'd0; value_one = 4'd7;
        do_reset("rst_lzb");
`ifdef COUNTDOWN_LZB_EN
        find_digit("lzb007_idx2", 4'b1011, 7'h7F, 1'b1);
        find_digit("lzb007_idx1", 4'b1101, 7'h7F, 1'b1);
`else
        find_digit("d007_idx2", 4'b1011, 7'b1000000, 1'b1);
        find_digit("d007_idx1", 4'b1101, 7'b1000000, 1'b1);
`endif
        find_digit("d007_idx0", 4'b1110, 7'b1111000, 1'b1);
        value_two = 4'd5; value_one = 4'd0;
`ifdef COUNTDOWN_LZB_EN
        find_digit("lzb050_idx2", 4'b1011, 7'h7F, 1'b1);
`else
        find_digit("d050_idx2", 4'b1011, 7'b1000000, 1'b1);
`endif
        find_digit("d050_idx1", 4'b1101, 7'b0010010, 1'b1);

        for (int a = 0; a < 2; a++) begin
            armed = a[0];
            for (int d = 0; d < 16; d++) begin
                value_one   = d[3:0];
                value_two   = 4'(d + 1);
                value_three = 4'(d + 2);
                repeat (16) tick();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
